// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator.
// Output register states, multiplier widths, counter helper.
package product_accumulator_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int MULT_AW    = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // All-ones value of a w-bit saturating counter.
  function automatic int sat_count(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums packets of unsigned multiplier products (dot-product reduce).
// Ports: clk, reset, in_valid/in_ready/product/in_last in,
//        out_valid/out_ready/sum/overflow/count out.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       product,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   sum,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] SAT =
    COUNT_WIDTH'(sat_count(COUNT_WIDTH));

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic                   acc_ovf;
  logic [COUNT_WIDTH-1:0] term_cnt;

  logic                   in_fire;
  logic [ACC_WIDTH:0]     add;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic                   ovf_next;
  logic [COUNT_WIDTH-1:0] cnt_next;

  assign in_ready = (state == EMPTY) | out_ready;
  assign in_fire  = in_valid & in_ready;

  // Extra top bit captures the carry out of the add.
  assign add = {1'b0, acc}
             + {{(ACC_WIDTH-WIDTH+1){1'b0}}, product};
  assign acc_next = add[ACC_WIDTH-1:0];
  assign ovf_next = acc_ovf | add[ACC_WIDTH];
  assign cnt_next = (term_cnt == SAT) ? term_cnt
                  : term_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      sum       <= '0;
      overflow  <= 1'b0;
      count     <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      term_cnt  <= '0;
    end else begin
      if (in_fire && in_last) begin
        // Replaces any result leaving this same edge.
        state     <= FULL;
        out_valid <= 1'b1;
        sum       <= acc_next;
        overflow  <= ovf_next;
        count     <= cnt_next;
        acc       <= '0;
        acc_ovf   <= 1'b0;
        term_cnt  <= '0;
      end else begin
        if (in_fire) begin
          acc      <= acc_next;
          acc_ovf  <= ovf_next;
          term_cnt <= cnt_next;
        end
        if (out_valid && out_ready) begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator.
// Expected results queued at accept, compared on transfer.
module tb_product_accumulator;

  logic        clk = 0;
  logic        reset = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  product = 0;
  logic        in_last = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [15:0] sum;
  logic        overflow;
  logic [3:0]  count;

  typedef struct {
    int s;
    int o;
    int c;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_acc = 0;
  int   m_cnt = 0;
  int   vcnt = 0;

  product_accumulator dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) vcnt++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        res_t r;
        r = q.pop_front();
        chk("sum", sum, r.s);
        chk("overflow", overflow, r.o);
        chk("count", count, r.c);
      end
    end
  end

  task automatic model(input int p, input bit last);
    m_acc += p;
    if (m_cnt < 15) m_cnt++;
    if (last) begin
      res_t r;
      r.s = m_acc % 65536;
      r.o = (m_acc > 65535) ? 1 : 0;
      r.c = m_cnt;
      q.push_back(r);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after accept.
  task automatic send(input int p, input bit last);
    int n = 0;
    in_valid = 1;
    product  = 8'(p);
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", in_ready, 1);
    if (in_ready) model(p, last);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 0;
    idle(1);

    // basic sum
    send(3, 0);
    send(5, 0);
    send(7, 1);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    @(negedge clk);
    chk("t1_drop", out_valid, 0);
    idle(1);

    // overflow and saturation
    for (int i = 0; i < 258; i++) send(255, i == 257);
    send(1, 0);
    send(2, 1);
    idle(2);

    // backpressure
    out_ready = 0;
    send(10, 0);
    send(20, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_sum", sum, 30);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1;
    product  = 9;
    in_last  = 0;
    @(negedge clk);
    chk("bp_stall", in_ready, 0);
    chk("bp_hold", sum, 30);
    @(posedge clk);
    #1;
    out_ready = 1;
    @(negedge clk);
    chk("bp_release", in_ready, 1);
    model(9, 0);
    @(posedge clk);
    #1;
    in_valid = 0;
    send(11, 1);
    idle(3);

    // back-to-back singles
    vcnt = 0;
    for (int i = 1; i <= 4; i++) send(i, 1);
    @(negedge clk);
    #1;
    chk("b2b_cont", vcnt, 4);
    idle(2);

    // reset mid-packet
    send(100, 0);
    send(100, 0);
    #3;
    reset = 1;
    #1;
    chk("amid_valid", out_valid, 0);
    chk("amid_sum", sum, 0);
    m_acc = 0;
    m_cnt = 0;
    q.delete();
    idle(2);
    reset = 0;
    idle(1);
    send(4, 1);
    idle(2);

    // input gaps
    send(50, 0);
    idle(3);
    send(60, 0);
    idle(1);
    send(70, 1);
    idle(3);

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the combinational array multiplier. Consumes its WIDTH-bit truncated products one per cycle and sums a packet of products, i.e. a dot-product reduction.
- A packet is delimited by `in_last`. When the last product is accepted, the block emits the packet sum with an overflow flag and a term count.
- Uses valid/ready handshakes on both sides. Holds a one-deep output register.

Parameters:
- `WIDTH`, 8, width of the incoming product (matches the multiplier output width).
- `ACC_WIDTH`, 16, width of the accumulator and of `sum`. Must satisfy `ACC_WIDTH >= WIDTH`.
- `COUNT_WIDTH`, 4, width of the term counter. It saturates at 2^COUNT_WIDTH-1.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `product` is valid this cycle.
- `in_ready`  output  1  block accepts `product` this cycle.
- `product`  input  WIDTH  unsigned product term.
- `in_last`  input  1  marks the final term of a packet. Qualified by `in_valid`.
- `out_valid`  output  1  `sum`, `overflow` and `count` are valid.
- `out_ready`  input  1  consumer takes the result this cycle.
- `sum`  output  ACC_WIDTH  packet sum modulo 2^ACC_WIDTH.
- `overflow`  output  1  packet sum exceeded 2^ACC_WIDTH-1.
- `count`  output  COUNT_WIDTH  number of terms in the packet, saturating.

Behaviour:
- **Reset (asynchronous, active-high)**
  - Clears `acc`, `acc_ovf` and `term_cnt`.
  - Clears `out_valid`, `sum`, `overflow` and `count` to 0.
  - Sets state to EMPTY.
  - A reset mid-packet discards the partial sum and any pending output.
- **Handshakes**
  - Input accept: `in_fire = in_valid & in_ready`.
  - Output transfer: `out_fire = out_valid & out_ready`.
- **Output register states:** EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
- **`in_ready`** = `(state==EMPTY) | out_ready`. This is combinational on `out_ready` and has no path from `in_valid`.
- **On `in_fire` without `in_last`:**
  - `acc <= acc + zero-extended product`.
  - `acc_ovf <= acc_ovf | carry-out` of that ACC_WIDTH-bit add.
  - `term_cnt <= term_cnt+1`, saturating at all-ones.
- **On `in_fire` with `in_last`:**
  - Compute `acc_next`, `ovf_next` and `cnt_next` exactly as above.
  - Load `sum <= acc_next`, `overflow <= ovf_next`, `count <= cnt_next`.
  - Set `out_valid <= 1` (state FULL).
  - Clear `acc`, `acc_ovf` and `term_cnt` to 0 in the same edge.
- **Latency:** the result is visible the cycle after the last term is accepted.
- **FULL with `out_ready=0`:**
  - `in_ready=0` and the input stalls.
  - Outputs hold stable until transferred.
- **FULL with `out_fire` and no `in_fire`-with-`in_last`:** go to EMPTY and clear `out_valid`. `sum`, `overflow` and `count` may hold their stale values.
- **Simultaneous `out_fire` and `in_fire`-with-`in_last` in FULL:** the new result replaces the old one in the same edge and `out_valid` stays 1. This gives back-to-back single-term packets at one result per cycle.
- **Between packets:** `in_valid=0` holds the accumulator unchanged. Gaps inside a packet are legal.
- **Single-term packet:** `sum = product`, `count = 1`.
- **Counter saturation:** `count` saturates. Terms beyond 2^COUNT_WIDTH-1 still accumulate into `sum`.
- **Arithmetic:** `sum` is unsigned with no sign handling. Overflow is sticky for the whole packet and cleared per packet.
- **Illegal combination:** `product` and `in_last` are ignored when `in_valid=0`.

Decomposition:
- Put the state encodings (EMPTY=1'b0, FULL=1'b1) and a `SAT_COUNT` localparam helper in the shared header `mult_defs.vh`, alongside the multiplier's width constants.
- No sub-module is needed: the block is a single module.
- The top-level pairs the multiplier's `y` with `product`.

Test Plan:
1. Basic sum: reset, then products 3, 5, 7 (`in_last` on 7) with `out_ready=1` -> one cycle later `out_valid=1`, `sum=15`, `count=3`, `overflow=0`. `out_valid` drops the next cycle.
2. Overflow and saturation: 258 terms of 255, the last flagged -> `sum=254` (65790 mod 65536), `overflow=1`, `count=15`. A following packet of 1, 2 (last) -> `sum=3`, `overflow=0`, `count=2`.
3. Backpressure: packet 10, 20 (last) with `out_ready=0` for 5 cycles -> `sum=30` held stable and `in_ready=0` throughout. With `in_valid` asserted and product 9 pending, nothing is accepted until `out_ready=1`. Then 9 is accepted in the same cycle as the transfer.
4. Back-to-back singles: `in_valid=1`, `in_last=1` every cycle with products 1, 2, 3, 4 and `out_ready=1` -> `sum` is 1, 2, 3, 4 on consecutive cycles, `out_valid` stays continuously 1, and `count=1` each time.
5. Reset mid-packet: products 100, 100 accepted, then assert `reset` asynchronously between clock edges -> `out_valid` and `sum` are 0 immediately. A subsequent packet 4 (last) gives `sum=4`, `count=1`, `overflow=0`.
6. Input gaps: 50, idle 3 cycles, 60, idle, 70 (last) -> `sum=180`, `count=3`. The accumulator is unchanged during idle cycles.
